// File: rtl/mito_ctrl_if.sv
`default_nettype none
// ============================================================================
// mito_ctrl_if : host handshake and buffer strobe bundle for mito_ctrl
// Rev 1.0
// ============================================================================
interface mito_ctrl_if #(
  parameter int K     = 3,
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             wgt_read;
  logic             bias_read;
  logic [K-1:0]     ifm_read;
  logic             ofm_valid;
  logic [CNT_W-1:0] ofm_row;
  logic [CNT_W-1:0] ofm_col;

  modport master (
    output start, abort,
    input  busy, done, wgt_read, bias_read, ifm_read, ofm_valid, ofm_row, ofm_col
  );

  modport slave (
    input  start, abort,
    output busy, done, wgt_read, bias_read, ifm_read, ofm_valid, ofm_row, ofm_col
  );
endinterface
`default_nettype wire

// File: rtl/mito_ctrl.sv
`default_nettype none
// ============================================================================
// mito_ctrl : KxK window sweep sequencer with PIPE_LAT-deep output tagging
// Rev 1.0
// ============================================================================
module mito_ctrl #(
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8,
  parameter int K        = 3,
  parameter int PIPE_LAT = 3,
  parameter int CNT_W    = 8
) (
  input wire          clk,
  input wire          rst_n,
  mito_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LD_WB = 3'd1,
    S_PRIME = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_PRIME_LAST = CNT_W'(K - 2);
  localparam logic [CNT_W-1:0] C_RUN_LAST   = CNT_W'(IMG_W - K);
  localparam logic [CNT_W-1:0] C_ROW_LAST   = CNT_W'(IMG_H - K);
  localparam logic [CNT_W-1:0] C_DRAIN_LAST = CNT_W'(PIPE_LAT - 1);
  // A 1-wide kernel has nothing to prime, so each row goes straight to RUN.
  localparam state_t C_ROW_ENTRY = (K > 1) ? S_PRIME : S_RUN;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wgt_q, wgt_d;
  logic             bias_q, bias_d;
  logic [K-1:0]     ifm_q, ifm_d;
  logic             flush;

  logic [PIPE_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [CNT_W-1:0]    pipe_row_q [PIPE_LAT];
  logic [CNT_W-1:0]    pipe_row_d [PIPE_LAT];
  logic [CNT_W-1:0]    pipe_col_q [PIPE_LAT];
  logic [CNT_W-1:0]    pipe_col_d [PIPE_LAT];

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    flush   = 1'b0;
    if ((state_q != S_IDLE) && bus.abort) begin
      state_d = S_IDLE;
      row_d   = '0;
      col_d   = '0;
      flush   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_LD_WB;
            row_d   = '0;
            col_d   = '0;
          end
        end
        S_LD_WB: begin
          state_d = C_ROW_ENTRY;
          row_d   = '0;
          col_d   = '0;
        end
        S_PRIME: begin
          if (col_q == C_PRIME_LAST) begin
            state_d = S_RUN;
            col_d   = '0;
          end else begin
            col_d = col_q + C_ONE;
          end
        end
        S_RUN: begin
          if (col_q == C_RUN_LAST) begin
            col_d = '0;
            if (row_q == C_ROW_LAST) begin
              state_d = S_DRAIN;
            end else begin
              row_d   = row_q + C_ONE;
              state_d = C_ROW_ENTRY;
            end
          end else begin
            col_d = col_q + C_ONE;
          end
        end
        S_DRAIN: begin
          // col counter doubles as the drain timer
          if (col_q == C_DRAIN_LAST) begin
            state_d = S_DONE;
            col_d   = '0;
          end else begin
            col_d = col_q + C_ONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Strobes follow the next state so they line up with the registered state.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    wgt_d  = (state_d == S_LD_WB);
    bias_d = (state_d == S_LD_WB);
    ifm_d  = {K{(state_d == S_PRIME) || (state_d == S_RUN)}};

    pipe_vld_d[0] = (state_q == S_RUN) && !flush;
    pipe_row_d[0] = pipe_vld_d[0] ? row_q : '0;
    pipe_col_d[0] = pipe_vld_d[0] ? col_q : '0;
    for (int i = 1; i < PIPE_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1] && !flush;
      pipe_row_d[i] = flush ? '0 : pipe_row_q[i-1];
      pipe_col_d[i] = flush ? '0 : pipe_col_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wgt_q      <= 1'b0;
      bias_q     <= 1'b0;
      ifm_q      <= '0;
      pipe_vld_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        pipe_row_q[i] <= '0;
        pipe_col_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wgt_q      <= wgt_d;
      bias_q     <= bias_d;
      ifm_q      <= ifm_d;
      pipe_vld_q <= pipe_vld_d;
      for (int i = 0; i < PIPE_LAT; i++) begin
        pipe_row_q[i] <= pipe_row_d[i];
        pipe_col_q[i] <= pipe_col_d[i];
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.wgt_read  = wgt_q;
  assign bus.bias_read = bias_q;
  assign bus.ifm_read  = ifm_q;
  assign bus.ofm_valid = pipe_vld_q[PIPE_LAT-1];
  assign bus.ofm_row   = pipe_row_q[PIPE_LAT-1];
  assign bus.ofm_col   = pipe_col_q[PIPE_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_mito_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mito_ctrl : scoreboard bench for mito_ctrl (default map plus a 3x3 map)
// Rev 1.0
// ============================================================================
module tb_mito_ctrl;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int K  = 3;
  localparam int PL = 3;
  localparam int CW = 8;
  localparam int HO = H - K + 1;
  localparam int WO = W - K + 1;
  localparam int DONE_CYC = 1 + HO * W + PL + 1;
  localparam int LAST_IFM = 1 + HO * W;
  localparam int PERIOD   = DONE_CYC + 1;

  typedef struct {
    int cyc;
    int row;
    int col;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total;
  int   bad;
  exp_t sbq[$];

  always #5 clk = ~clk;

  mito_ctrl_if #(.K(K), .CNT_W(CW)) bus ();
  mito_ctrl_if #(.K(3), .CNT_W(CW)) sbus ();

  mito_ctrl #(.IMG_W(W), .IMG_H(H), .K(K), .PIPE_LAT(PL), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mito_ctrl #(.IMG_W(3), .IMG_H(3), .K(3), .PIPE_LAT(1), .CNT_W(CW)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus)
  );

  // Expected output tags with the cycle (relative to the start edge) each must appear in.
  function automatic void push_map(int offset);
    for (int r = 0; r < HO; r++)
      for (int c = 0; c < WO; c++)
        sbq.push_back('{cyc: offset + 2 + r * W + (K - 1) + c + PL, row: r, col: c});
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.wgt_read, bus.bias_read, bus.ifm_read, bus.ofm_valid} !== 8'b0) begin
      bad++; $display("FAIL reset_strobes got=%b want=0", {bus.busy, bus.done, bus.wgt_read, bus.bias_read, bus.ifm_read, bus.ofm_valid});
    end
    total++;
    if ({bus.ofm_row, bus.ofm_col} !== 16'h0) begin
      bad++; $display("FAIL reset_tags got=%h want=0", {bus.ofm_row, bus.ofm_col});
    end
    total++;
    if ({sbus.busy, sbus.done, sbus.ofm_valid} !== 3'b0) begin
      bad++; $display("FAIL reset_small got=%b want=0", {sbus.busy, sbus.done, sbus.ofm_valid});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle busy got=%b want=0", bus.busy);
    end
  endtask

  task automatic test_full_map();
    exp_t         e;
    logic         exp_v;
    logic [K-1:0] exp_ifm;
    int           nvalid = 0;
    sbq.delete();
    push_map(0);
    bus.start = 1'b1;
    for (int k = 1; k <= DONE_CYC + 3; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      exp_ifm = (k >= 2 && k <= LAST_IFM) ? '1 : '0;
      total++;
      if (bus.busy !== (k <= DONE_CYC)) begin
        bad++; $display("FAIL map_busy cyc=%0d got=%b want=%b", k, bus.busy, (k <= DONE_CYC));
      end
      total++;
      if ({bus.wgt_read, bus.bias_read} !== {2{k == 1}}) begin
        bad++; $display("FAIL map_wgt_bias cyc=%0d got=%b want=%b", k, {bus.wgt_read, bus.bias_read}, {2{k == 1}});
      end
      total++;
      if (bus.ifm_read !== exp_ifm) begin
        bad++; $display("FAIL map_ifm cyc=%0d got=%b want=%b", k, bus.ifm_read, exp_ifm);
      end
      total++;
      if (bus.done !== (k == DONE_CYC)) begin
        bad++; $display("FAIL map_done cyc=%0d got=%b want=%b", k, bus.done, (k == DONE_CYC));
      end
      exp_v = (sbq.size() > 0) && (sbq[0].cyc == k);
      total++;
      if (bus.ofm_valid !== exp_v) begin
        bad++; $display("FAIL map_valid cyc=%0d got=%b want=%b", k, bus.ofm_valid, exp_v);
      end
      if (exp_v) begin
        e = sbq.pop_front();
        nvalid++;
        total++;
        if (bus.ofm_row !== CW'(e.row) || bus.ofm_col !== CW'(e.col)) begin
          bad++; $display("FAIL map_tag cyc=%0d got=(%0d,%0d) want=(%0d,%0d)", k, bus.ofm_row, bus.ofm_col, e.row, e.col);
        end
      end
    end
    total++;
    if (nvalid != WO * HO || sbq.size() != 0) begin
      bad++; $display("FAIL map_count got=%0d want=%0d", nvalid, WO * HO);
    end
  endtask

  task automatic test_start_abort_idle();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    total++;
    if ({bus.busy, bus.wgt_read} !== 2'b11) begin
      bad++; $display("FAIL start_wins got=%b want=11", {bus.busy, bus.wgt_read});
    end
    @(negedge clk);
    bus.abort = 1'b0;
    total++;
    if ({bus.busy, bus.ifm_read} !== 4'b0) begin
      bad++; $display("FAIL abort_ldwb got=%b want=0", {bus.busy, bus.ifm_read});
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL abort_idle busy got=%b want=0", bus.busy);
    end
  endtask

  task automatic test_abort();
    exp_t e;
    logic exp_v;
    sbq.delete();
    push_map(0);
    bus.start = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k <= 20) begin
        exp_v = (sbq.size() > 0) && (sbq[0].cyc == k);
        total++;
        if (bus.ofm_valid !== exp_v) begin
          bad++; $display("FAIL abort_pre_valid cyc=%0d got=%b want=%b", k, bus.ofm_valid, exp_v);
        end
        if (exp_v) begin
          e = sbq.pop_front();
          total++;
          if (bus.ofm_row !== CW'(e.row) || bus.ofm_col !== CW'(e.col)) begin
            bad++; $display("FAIL abort_pre_tag cyc=%0d got=(%0d,%0d) want=(%0d,%0d)", k, bus.ofm_row, bus.ofm_col, e.row, e.col);
          end
        end
      end else begin
        total++;
        if ({bus.busy, bus.done, bus.wgt_read, bus.bias_read, bus.ifm_read, bus.ofm_valid} !== 8'b0) begin
          bad++; $display("FAIL abort_post cyc=%0d got=%b want=0", k, {bus.busy, bus.done, bus.wgt_read, bus.bias_read, bus.ifm_read, bus.ofm_valid});
        end
      end
      if (k == 20) bus.abort = 1'b1;
      if (k == 21) bus.abort = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    bus.start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
    end
    total++;
    if ({bus.busy, bus.ifm_read} !== 4'b1111) begin
      bad++; $display("FAIL areset_pre got=%b want=1111", {bus.busy, bus.ifm_read});
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.wgt_read, bus.bias_read, bus.ifm_read, bus.ofm_valid} !== 8'b0) begin
      bad++; $display("FAIL areset_async got=%b want=0", {bus.busy, bus.done, bus.wgt_read, bus.bias_read, bus.ifm_read, bus.ofm_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      total++;
      if ({bus.busy, bus.done, bus.ifm_read, bus.ofm_valid} !== 6'b0) begin
        bad++; $display("FAIL areset_idle cyc=%0d got=%b want=0", k, {bus.busy, bus.done, bus.ifm_read, bus.ofm_valid});
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic exp_v;
    logic exp_busy;
    int   ndone = 0;
    int   nvalid = 0;
    sbq.delete();
    push_map(0);
    push_map(PERIOD);
    bus.start = 1'b1;
    for (int k = 1; k <= 2 * PERIOD + 3; k++) begin
      @(negedge clk);
      exp_busy = !((k == PERIOD) || (k > PERIOD + DONE_CYC));
      total++;
      if (bus.busy !== exp_busy) begin
        bad++; $display("FAIL b2b_busy cyc=%0d got=%b want=%b", k, bus.busy, exp_busy);
      end
      total++;
      if (bus.wgt_read !== (k == 1 || k == PERIOD + 1)) begin
        bad++; $display("FAIL b2b_wgt cyc=%0d got=%b want=%b", k, bus.wgt_read, (k == 1 || k == PERIOD + 1));
      end
      total++;
      if (bus.done !== (k == DONE_CYC || k == PERIOD + DONE_CYC)) begin
        bad++; $display("FAIL b2b_done cyc=%0d got=%b", k, bus.done);
      end
      if (bus.done === 1'b1) ndone++;
      exp_v = (sbq.size() > 0) && (sbq[0].cyc == k);
      total++;
      if (bus.ofm_valid !== exp_v) begin
        bad++; $display("FAIL b2b_valid cyc=%0d got=%b want=%b", k, bus.ofm_valid, exp_v);
      end
      if (exp_v) begin
        e = sbq.pop_front();
        nvalid++;
        total++;
        if (bus.ofm_row !== CW'(e.row) || bus.ofm_col !== CW'(e.col)) begin
          bad++; $display("FAIL b2b_tag cyc=%0d got=(%0d,%0d) want=(%0d,%0d)", k, bus.ofm_row, bus.ofm_col, e.row, e.col);
        end
      end
      if (k == PERIOD + DONE_CYC) bus.start = 1'b0;
    end
    total++;
    if (ndone != 2 || nvalid != 2 * WO * HO) begin
      bad++; $display("FAIL b2b_count got done=%0d valid=%0d want done=2 valid=%0d", ndone, nvalid, 2 * WO * HO);
    end
  endtask

  task automatic test_small();
    exp_t e;
    logic exp_v;
    sbq.delete();
    sbq.push_back('{cyc: 5, row: 0, col: 0});
    sbus.start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) sbus.start = 1'b0;
      total++;
      if ({sbus.busy, sbus.done} !== {(k <= 6), (k == 6)}) begin
        bad++; $display("FAIL small_busy_done cyc=%0d got=%b want=%b", k, {sbus.busy, sbus.done}, {(k <= 6), (k == 6)});
      end
      exp_v = (sbq.size() > 0) && (sbq[0].cyc == k);
      total++;
      if (sbus.ofm_valid !== exp_v) begin
        bad++; $display("FAIL small_valid cyc=%0d got=%b want=%b", k, sbus.ofm_valid, exp_v);
      end
      if (exp_v) begin
        e = sbq.pop_front();
        total++;
        if (sbus.ofm_row !== CW'(e.row) || sbus.ofm_col !== CW'(e.col)) begin
          bad++; $display("FAIL small_tag got=(%0d,%0d) want=(%0d,%0d)", sbus.ofm_row, sbus.ofm_col, e.row, e.col);
        end
      end
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    sbus.start = 1'b0;
    sbus.abort = 1'b0;
    test_reset();
    @(negedge clk);
    test_full_map();
    test_start_abort_idle();
    test_abort();
    test_full_map();
    test_async_reset();
    test_back_to_back();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
